// File: rtl/roteamento_demux_if.sv
// Bus between the shared routing channel, the demux and its two destinations.
// The master modport is the channel/destination side; the slave modport is the demux.
interface roteamento_demux_if #(
  parameter int N = 4
);
  logic [N-1:0] Entrada;
  logic         SEL;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] B;
  logic         b_valid;
  logic         b_ready;

  modport master (
    output Entrada, SEL, in_valid, a_ready, b_ready,
    input  in_ready, A, a_valid, B, b_valid
  );

  modport slave (
    input  Entrada, SEL, in_valid, a_ready, b_ready,
    output in_ready, A, a_valid, B, b_valid
  );
endinterface

// File: rtl/roteamento_demux.sv
// Receiving end of the routing channel: steers each word into a per-destination FIFO (A or B) by SEL.
// Optional pop counters cnt_a/cnt_b are enabled with the macro ROTEAMENTO_CONTADOR_EN.
module roteamento_demux #(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  roteamento_demux_if.slave  bus
`ifdef ROTEAMENTO_CONTADOR_EN
  , output logic [7:0]       cnt_a
  , output logic [7:0]       cnt_b
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Index 0 is destination A, index 1 is destination B.
  logic [N-1:0]  r_mem   [2][DEPTH];
  logic [PW-1:0] r_wrPtr [2];
  logic [PW-1:0] r_rdPtr [2];
  logic [CW-1:0] r_count [2];

  logic [1:0] w_full;
  logic [1:0] w_empty;
  logic [1:0] w_push;
  logic [1:0] w_pop;

  assign w_full[0]  = (r_count[0] == CW'(DEPTH));
  assign w_full[1]  = (r_count[1] == CW'(DEPTH));
  assign w_empty[0] = (r_count[0] == '0);
  assign w_empty[1] = (r_count[1] == '0);

  // Readiness uses the pre-pop count, so a full FIFO refuses a push even while it is popping.
  assign bus.in_ready = !w_full[bus.SEL];

  assign w_push[0] = bus.in_valid && !bus.SEL && !w_full[0];
  assign w_push[1] = bus.in_valid &&  bus.SEL && !w_full[1];
  assign w_pop[0]  = bus.a_ready && !w_empty[0];
  assign w_pop[1]  = bus.b_ready && !w_empty[1];

  assign bus.a_valid = !w_empty[0];
  assign bus.b_valid = !w_empty[1];
  assign bus.A       = w_empty[0] ? '0 : r_mem[0][r_rdPtr[0]];
  assign bus.B       = w_empty[1] ? '0 : r_mem[1][r_rdPtr[1]];

  always_ff @(posedge clock) begin
    for (int f = 0; f < 2; f++) begin
      if (w_push[f]) begin
        r_mem[f][r_wrPtr[f]] <= bus.Entrada;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int f = 0; f < 2; f++) begin
        r_wrPtr[f] <= '0;
        r_rdPtr[f] <= '0;
        r_count[f] <= '0;
      end
    end else begin
      for (int f = 0; f < 2; f++) begin
        if (w_push[f]) begin
          r_wrPtr[f] <= r_wrPtr[f] + PW'(1);
        end
        if (w_pop[f]) begin
          r_rdPtr[f] <= r_rdPtr[f] + PW'(1);
        end
        case ({w_push[f], w_pop[f]})
          2'b10:   r_count[f] <= r_count[f] + CW'(1);
          2'b01:   r_count[f] <= r_count[f] - CW'(1);
          default: r_count[f] <= r_count[f];
        endcase
      end
    end
  end

`ifdef ROTEAMENTO_CONTADOR_EN
  logic [7:0] r_cntA;
  logic [7:0] r_cntB;

  // Pop counters stick at 255 instead of wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cntA <= '0;
      r_cntB <= '0;
    end else begin
      if (w_pop[0] && (r_cntA != 8'hFF)) begin
        r_cntA <= r_cntA + 8'd1;
      end
      if (w_pop[1] && (r_cntB != 8'hFF)) begin
        r_cntB <= r_cntB + 8'd1;
      end
    end
  end

  assign cnt_a = r_cntA;
  assign cnt_b = r_cntB;
`endif

endmodule

// File: tb/tb_roteamento_demux.sv
// Directed self-checking bench for roteamento_demux (N=4, DEPTH=2).
// Pop-counter scenarios run only when ROTEAMENTO_CONTADOR_EN is defined.
module tb_roteamento_demux;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  roteamento_demux_if #(.N(4)) bus ();

`ifdef ROTEAMENTO_CONTADOR_EN
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
`endif

  roteamento_demux #(.N(4), .DEPTH(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ROTEAMENTO_CONTADOR_EN
    , .cnt_a (cnt_a)
    , .cnt_b (cnt_b)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n      = 1'b1;
    bus.Entrada  = 4'h0;
    bus.SEL      = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    #2;
    reset_n = 1'b0;
    tick();
    tick();
    total++; if (bus.a_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_a_valid got=%b exp=0", bus.a_valid); end
    total++; if (bus.b_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_b_valid got=%b exp=0", bus.b_valid); end
    total++; if (bus.A !== 4'h0) begin bad++; $display("[TB] FAIL reset_A got=%h exp=0", bus.A); end
    total++; if (bus.B !== 4'h0) begin bad++; $display("[TB] FAIL reset_B got=%h exp=0", bus.B); end
    reset_n = 1'b1;
    tick();
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready_sel0 got=%b exp=1", bus.in_ready); end
    bus.SEL = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready_sel1 got=%b exp=1", bus.in_ready); end
    bus.SEL = 1'b0;
  endtask

  task automatic test_single_routing();
    bus.Entrada  = 4'hA;
    bus.SEL      = 1'b0;
    bus.in_valid = 1'b1;
    bus.a_ready  = 1'b0;
    #1;
    total++; if (bus.a_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_no_bypass got=%b exp=0", bus.a_valid); end
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.a_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_a_valid got=%b exp=1", bus.a_valid); end
    total++; if (bus.A !== 4'hA) begin bad++; $display("[TB] FAIL single_A got=%h exp=a", bus.A); end
    total++; if (bus.b_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_b_valid got=%b exp=0", bus.b_valid); end
    bus.a_ready = 1'b1;
    tick();
    bus.a_ready = 1'b0;
    total++; if (bus.a_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_pop_a_valid got=%b exp=0", bus.a_valid); end
    total++; if (bus.A !== 4'h0) begin bad++; $display("[TB] FAIL single_pop_A got=%h exp=0", bus.A); end
    // Extra ready pulse on an empty FIFO must not underflow.
    bus.a_ready = 1'b1;
    tick();
    bus.a_ready = 1'b0;
    total++; if (bus.a_valid !== 1'b0) begin bad++; $display("[TB] FAIL underflow_a_valid got=%b exp=0", bus.a_valid); end
  endtask

  task automatic test_backpressure();
    bus.a_ready  = 1'b0;
    bus.SEL      = 1'b0;
    bus.in_valid = 1'b1;
    bus.Entrada  = 4'h1;
    tick();
    bus.Entrada  = 4'h2;
    tick();
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready_sel0 got=%b exp=0", bus.in_ready); end
    bus.SEL = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_in_ready_sel1 got=%b exp=1", bus.in_ready); end
    bus.Entrada  = 4'h7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.b_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_b_valid got=%b exp=1", bus.b_valid); end
    total++; if (bus.B !== 4'h7) begin bad++; $display("[TB] FAIL bp_B got=%h exp=7", bus.B); end
    total++; if (bus.A !== 4'h1) begin bad++; $display("[TB] FAIL bp_A_head got=%h exp=1", bus.A); end
    bus.a_ready = 1'b1;
    tick();
    total++; if (bus.A !== 4'h2) begin bad++; $display("[TB] FAIL bp_A_second got=%h exp=2", bus.A); end
    tick();
    bus.a_ready = 1'b0;
    total++; if (bus.a_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_a_drained got=%b exp=0", bus.a_valid); end
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    total++; if (bus.b_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_b_drained got=%b exp=0", bus.b_valid); end
  endtask

  task automatic test_full_simultaneous_pop();
    bus.SEL      = 1'b0;
    bus.in_valid = 1'b1;
    bus.Entrada  = 4'h3;
    tick();
    bus.Entrada  = 4'h4;
    tick();
    bus.Entrada  = 4'h5;
    bus.a_ready  = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fullpop_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    bus.a_ready = 1'b0;
    total++; if (bus.A !== 4'h4) begin bad++; $display("[TB] FAIL fullpop_A_head got=%h exp=4", bus.A); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL fullpop_in_ready_next got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fullpop_refull got=%b exp=0", bus.in_ready); end
    total++; if (bus.A !== 4'h4) begin bad++; $display("[TB] FAIL fullpop_A_still4 got=%h exp=4", bus.A); end
    bus.a_ready = 1'b1;
    tick();
    total++; if (bus.A !== 4'h5) begin bad++; $display("[TB] FAIL fullpop_A_then5 got=%h exp=5", bus.A); end
    tick();
    bus.a_ready = 1'b0;
    total++; if (bus.a_valid !== 1'b0) begin bad++; $display("[TB] FAIL fullpop_drained got=%b exp=0", bus.a_valid); end
  endtask

  task automatic test_pointer_wrap();
    logic [3:0] word;
    bus.SEL      = 1'b1;
    bus.b_ready  = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      word = 4'(i);
      bus.Entrada = word;
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL wrap_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      tick();
      total++; if (bus.b_valid !== 1'b1 || bus.B !== word) begin bad++; $display("[TB] FAIL wrap_B[%0d] got=%b/%h exp=1/%h", i, bus.b_valid, bus.B, word); end
    end
    bus.in_valid = 1'b0;
    tick();
    bus.b_ready = 1'b0;
    total++; if (bus.b_valid !== 1'b0) begin bad++; $display("[TB] FAIL wrap_drained got=%b exp=0", bus.b_valid); end
  endtask

  task automatic test_reset_mid();
`ifdef ROTEAMENTO_CONTADOR_EN
    total++; if (cnt_a !== 8'd6) begin bad++; $display("[TB] FAIL cnt_a_before_reset got=%0d exp=6", cnt_a); end
    total++; if (cnt_b !== 8'd9) begin bad++; $display("[TB] FAIL cnt_b_before_reset got=%0d exp=9", cnt_b); end
`endif
    bus.in_valid = 1'b1;
    bus.SEL      = 1'b0;
    bus.Entrada  = 4'h9;
    tick();
    bus.SEL      = 1'b1;
    bus.Entrada  = 4'h6;
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_loaded got=%b%b exp=11", bus.a_valid, bus.b_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_valid got=%b%b exp=00", bus.a_valid, bus.b_valid); end
    total++; if (bus.A !== 4'h0 || bus.B !== 4'h0) begin bad++; $display("[TB] FAIL mid_reset_data got=%h%h exp=00", bus.A, bus.B); end
`ifdef ROTEAMENTO_CONTADOR_EN
    total++; if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin bad++; $display("[TB] FAIL mid_reset_cnt got=%0d/%0d exp=0/0", cnt_a, cnt_b); end
`endif
    tick();
    reset_n = 1'b1;
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    tick();
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    total++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_after_release got=%b%b exp=00", bus.a_valid, bus.b_valid); end
    bus.SEL = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_in_ready got=%b exp=1", bus.in_ready); end
  endtask

`ifdef ROTEAMENTO_CONTADOR_EN
  task automatic test_counter_saturation();
    bus.SEL      = 1'b0;
    bus.a_ready  = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      bus.Entrada = 4'(i);
      tick();
    end
    total++; if (cnt_a !== 8'd254) begin bad++; $display("[TB] FAIL cnt_a_254 got=%0d exp=254", cnt_a); end
    for (int i = 0; i < 45; i++) begin
      bus.Entrada = 4'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    bus.a_ready = 1'b0;
    total++; if (cnt_a !== 8'd255) begin bad++; $display("[TB] FAIL cnt_a_saturate got=%0d exp=255", cnt_a); end
    total++; if (cnt_b !== 8'd0) begin bad++; $display("[TB] FAIL cnt_b_idle got=%0d exp=0", cnt_b); end
    total++; if (bus.a_valid !== 1'b0) begin bad++; $display("[TB] FAIL cnt_a_drained got=%b exp=0", bus.a_valid); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_routing();
    test_backpressure();
    test_full_simultaneous_pop();
    test_pointer_wrap();
    test_reset_mid();
`ifdef ROTEAMENTO_CONTADOR_EN
    test_counter_saturation();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/roteamento_demux.md
Name: roteamento_demux

Overview:
- Receiving end of the routing channel: takes N-bit words from the single shared channel plus the SEL tag that travelled with them, and delivers each word to destination A (SEL=0) or destination B (SEL=1).
- Each destination has its own DEPTH-entry FIFO with a valid/ready handshake, so a stalled destination never blocks traffic to the other.
- Sits at the far end of the channel driven by the 2:1 router.

Parameters:
- N, 4, data width in bits (same N as the router).
- DEPTH, 2, entries per destination FIFO; power of 2, ≥2.

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- Entrada  input  N  word on the shared channel.
- SEL  input  1  destination tag: 0 = A, 1 = B.
- in_valid  input  1  Entrada/SEL valid this cycle.
- in_ready  output  1  demux can accept the current word.
- A  output  N  head word of FIFO A.
- a_valid  output  1  FIFO A not empty.
- a_ready  input  1  destination A consumes head.
- B  output  N  head word of FIFO B.
- b_valid  output  1  FIFO B not empty.
- b_ready  input  1  destination B consumes head.

Behaviour:
- Reset (reset_n=0, async, takes effect immediately):
  - both FIFOs empty, read/write pointers 0, occupancy counts 0.
  - a_valid=b_valid=0, A=B=0.
  - in_ready reflects empty FIFOs (=1) once reset_n returns to 1.
  - Reset mid-transfer discards all stored words; no partial delivery.
- in_ready is combinational: in_ready = !full[SEL]. It depends on the current SEL.
- Push: on a rising edge with in_valid && in_ready, Entrada is written at the write pointer of FIFO[SEL]. That write pointer increments mod DEPTH, and that count +1.
- in_valid=1 while in_ready=0: word is not taken and no state changes. The sender must hold Entrada/SEL stable until accepted.
- Pop A: on a rising edge with a_valid && a_ready, the read pointer of A increments mod DEPTH and the count −1. B works the same way.
- a_ready while a_valid=0 is ignored. No underflow; pointers do not move.
- Latency: a word accepted at edge k appears on A/B with valid=1 after edge k. There is no same-cycle bypass.
- Ordering: per-destination FIFO order is preserved. No ordering exists between A and B.
- A = head entry when a_valid=1, else 0. B is the same.
- Full FIFO with simultaneous pop: in_ready is computed from the pre-pop count, so it is 0 and no push occurs that cycle. The pop proceeds. in_ready rises the next cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Push to one FIFO and pop from the other in the same cycle: fully independent.
- Occupancy count width: $clog2(DEPTH+1). Full: count==DEPTH. Empty: count==0.

Optional Feature:
- Macro: ROTEAMENTO_CONTADOR_EN.
- With the macro defined, two extra outputs exist:
  - cnt_a, 8 bits: number of words popped from A.
  - cnt_b, 8 bits: number of words popped from B.
  - Both reset to 0 asynchronously, increment on each pop, and saturate at 255 (no wrap).
- Without the macro, the ports and registers do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset then idle: reset_n=0 → a_valid=b_valid=0, A=B=0. After release with SEL=0 → in_ready=1.
- Single routing: push Entrada=4'hA with SEL=0, a_ready=0 → next cycle a_valid=1, A=4'hA, b_valid=0. Pulse a_ready → a_valid=0, A=0.
- Full/backpressure: a_ready=0, push 4'h1, 4'h2 to A → in_ready=0 with SEL=0 but 1 with SEL=1. Push 4'h7 to B → b_valid=1, B=4'h7. Then a_ready=1 → A reads 4'h1, then 4'h2 in order.
- Full with simultaneous pop: A full (4'h3, 4'h4), in_valid=1, SEL=0, a_ready=1 for one cycle → 4'h3 popped, nothing pushed. Next cycle in_ready=1, and a push of 4'h5 gives final A order 4'h4 then 4'h5.
- Pointer wrap: stream 8 words 0..7 to B with b_ready=1 continuously, DEPTH=2 → B emits 0..7 in order, one per cycle after a 1-cycle latency, and in_ready never drops.
- Reset mid-operation: both FIFOs hold data, reset_n pulsed low mid-cycle → a_valid=b_valid=0 immediately. With ROTEAMENTO_CONTADOR_EN defined, cnt_a=cnt_b=0. After 300 pops to A, cnt_a=255.
